// File: rtl/eeprom_ctrl.sv
// Byte read/write controller for an AT28C64-style parallel EEPROM.
// Writes complete by DATA-polling I/O7, giving up after POLL_MAX polls.
module eeprom_ctrl #(
  parameter int unsigned RD_WAIT  = 2,
  parameter int unsigned WE_PULSE = 3,
  parameter int unsigned POLL_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [12:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic [12:0] rom_a,
  output logic        rom_ce_n,
  output logic        rom_oe_n,
  output logic        rom_we_n,
  output logic [7:0]  rom_io_out,
  output logic        rom_io_oe,
  input  logic [7:0]  rom_io_in
);

  localparam int unsigned CNT_MAX = (RD_WAIT > WE_PULSE) ? RD_WAIT : WE_PULSE;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam int unsigned PW      = $clog2(POLL_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD,
    S_POLL,
    S_POLL_GAP,
    S_RESP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [PW-1:0] poll_cnt;

  // Strobes are registered and forced inactive asynchronously on reset,
  // so an aborted write pulse ends immediately. rom_io_out[7] doubles as
  // the DATA-poll reference bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      poll_cnt   <= '0;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      rom_a      <= '0;
      rom_ce_n   <= 1'b1;
      rom_oe_n   <= 1'b1;
      rom_we_n   <= 1'b1;
      rom_io_out <= '0;
      rom_io_oe  <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            rom_a      <= req_addr;
            rom_io_out <= req_wdata;
            cnt        <= '0;
            req_ready  <= 1'b0;
            rom_ce_n   <= 1'b0;
            if (req_we) begin
              rom_io_oe <= 1'b1;
              state     <= S_WR_SETUP;
            end else begin
              rom_oe_n <= 1'b0;
              state    <= S_RD;
            end
          end
        end
        S_RD: begin
          if (cnt == CW'(RD_WAIT - 1)) begin
            rsp_rdata <= rom_io_in;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            rom_ce_n  <= 1'b1;
            rom_oe_n  <= 1'b1;
            state     <= S_RESP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_WR_SETUP: begin
          rom_we_n <= 1'b0;
          cnt      <= '0;
          state    <= S_WR_PULSE;
        end
        S_WR_PULSE: begin
          if (cnt == CW'(WE_PULSE - 1)) begin
            rom_we_n <= 1'b1;
            state    <= S_WR_HOLD;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_WR_HOLD: begin
          // Release the bus in the same edge that opens the read strobe.
          rom_io_oe <= 1'b0;
          rom_oe_n  <= 1'b0;
          cnt       <= '0;
          state     <= S_POLL;
        end
        S_POLL: begin
          if (cnt == CW'(RD_WAIT - 1)) begin
            rom_ce_n <= 1'b1;
            rom_oe_n <= 1'b1;
            if (rom_io_in[7] == rom_io_out[7]) begin
              rsp_err   <= 1'b0;
              rsp_valid <= 1'b1;
              state     <= S_RESP;
            end else if (poll_cnt == PW'(POLL_MAX - 1)) begin
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
              state     <= S_RESP;
            end else begin
              state <= S_POLL_GAP;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_POLL_GAP: begin
          poll_cnt <= poll_cnt + PW'(1);
          rom_ce_n <= 1'b0;
          rom_oe_n <= 1'b0;
          cnt      <= '0;
          state    <= S_POLL;
        end
        S_RESP: begin
          poll_cnt  <= '0;
          req_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eeprom_ctrl.sv
// Bench for eeprom_ctrl: behavioural EEPROM with DATA-poll busy emulation,
// a cycle-level reference model of the pin/response timing, and directed tests.
module tb_eeprom_ctrl;

  localparam int unsigned RD_WAIT  = 2;
  localparam int unsigned WE_PULSE = 3;
  localparam int unsigned POLL_MAX = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [12:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic [12:0] rom_a;
  logic        rom_ce_n, rom_oe_n, rom_we_n;
  logic [7:0]  rom_io_out;
  logic        rom_io_oe;
  logic [7:0]  rom_io_in;

  always #5 clk = ~clk;

  eeprom_ctrl #(.RD_WAIT(RD_WAIT), .WE_PULSE(WE_PULSE), .POLL_MAX(POLL_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rom_a(rom_a), .rom_ce_n(rom_ce_n), .rom_oe_n(rom_oe_n), .rom_we_n(rom_we_n),
    .rom_io_out(rom_io_out), .rom_io_oe(rom_io_oe), .rom_io_in(rom_io_in)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // EEPROM: commits on we_n rising, then reports ~data[7] on busy_cfg polls of that byte.
  logic [7:0]  mem [8192];
  int          busy_cfg = 0;
  int          busy_left;
  logic [12:0] busy_addr;

  initial begin
    logic we_q, oe_q;
    for (int i = 0; i < 8192; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[5] = 8'hA5;
    busy_left = 0;
    busy_addr = '0;
    we_q = 1'b1;
    oe_q = 1'b1;
    forever begin
      @(rom_we_n or rom_oe_n);
      if (rom_we_n && !we_q && rst_n && !rom_ce_n && rom_io_oe) begin
        mem[rom_a] = rom_io_out;
        busy_addr  = rom_a;
        busy_left  = busy_cfg;
      end
      if (rom_oe_n && !oe_q && busy_left > 0 && rom_a == busy_addr) busy_left--;
      we_q = rom_we_n;
      oe_q = rom_oe_n;
    end
  end

  always_comb begin
    if (!rom_ce_n && !rom_oe_n) begin
      if (busy_left > 0 && rom_a == busy_addr) rom_io_in = {~mem[rom_a][7], mem[rom_a][6:0]};
      else rom_io_in = mem[rom_a];
    end else begin
      rom_io_in = 8'hEE;
    end
  end

  // Reference model: one transaction at a time, timing derived from phase lengths.
  logic [7:0]  ref_mem [8192];
  logic        active, kind, terr;
  int          acc_cyc, lat, kk, cyc, n_acc;
  logic [12:0] taddr;
  logic [7:0]  twdata, hold_rd;

  initial begin
    for (int i = 0; i < 8192; i++) ref_mem[i] = 8'(i) ^ 8'h5A;
    ref_mem[5] = 8'hA5;
    active = 1'b0; kind = 1'b0; terr = 1'b0;
    acc_cyc = 0; lat = 0; kk = 0; cyc = 0; n_acc = 0;
    taddr = '0; twdata = '0; hold_rd = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        active  = 1'b0;
        hold_rd = '0;
      end else begin
        if (active && cyc == acc_cyc + lat) begin
          active = 1'b0;
          if (!kind) hold_rd = ref_mem[taddr];
        end else if (!active && req_valid) begin
          active  = 1'b1;
          kind    = req_we;
          acc_cyc = cyc;
          taddr   = req_addr;
          twdata  = req_wdata;
          n_acc++;
          if (req_we) begin
            kk   = (busy_cfg + 1 < int'(POLL_MAX)) ? busy_cfg + 1 : int'(POLL_MAX);
            terr = (busy_cfg >= int'(POLL_MAX));
            lat  = int'(WE_PULSE) + 2 + kk * (int'(RD_WAIT) + 1);
            ref_mem[req_addr] = req_wdata;
          end else begin
            kk   = 0;
            terr = 1'b0;
            lat  = int'(RD_WAIT) + 1;
          end
        end
        cyc++;
      end
    end
  end

  // Expected {ce_n, oe_n, we_n, io_oe} at cycle t after accept.
  function automatic logic [3:0] pins(input logic w, input int t, input int k);
    int u, j, r;
    if (!w) return (t >= 1 && t <= int'(RD_WAIT)) ? 4'b0010 : 4'b1110;
    if (t == 1) return 4'b0111;
    if (t >= 2 && t <= int'(WE_PULSE) + 1) return 4'b0101;
    if (t == int'(WE_PULSE) + 2) return 4'b0111;
    u = t - (int'(WE_PULSE) + 3);
    j = u / (int'(RD_WAIT) + 1);
    r = u % (int'(RD_WAIT) + 1);
    if (u >= 0 && j < k && r < int'(RD_WAIT)) return 4'b0010;
    return 4'b1110;
  endfunction

  // Per-cycle comparison plus recorders for the directed checks.
  int         rsp_cnt = 0, last_rel = 0, we_first = -1, we_last = -1, polls = 0, seen_acc = 0;
  logic [7:0] last_rdata = '0;
  logic       last_err = 1'b0;
  logic       oe_prev = 1'b1;

  always @(negedge clk) begin
    int         t;
    logic [3:0] ep;
    logic [7:0] exp_rd;
    logic       resp_now;
    t        = active ? (cyc - acc_cyc) : 0;
    resp_now = active && (t == lat);
    ep       = active ? pins(kind, t, kk) : 4'b1110;
    exp_rd   = (resp_now && !kind) ? ref_mem[taddr] : hold_rd;
    if (n_acc != seen_acc) begin
      seen_acc = n_acc;
      we_first = -1;
      we_last  = -1;
      polls    = 0;
    end
    check("req_ready", 32'(req_ready), 32'(!active));
    check("rsp_valid", 32'(rsp_valid), 32'(resp_now));
    check("pins ce/oe/we/io_oe", 32'({rom_ce_n, rom_oe_n, rom_we_n, rom_io_oe}), 32'(ep));
    check("rsp_rdata", 32'(rsp_rdata), 32'(exp_rd));
    if (resp_now) check("rsp_err", 32'(rsp_err), 32'(terr));
    if (active) check("rom_a", 32'(rom_a), 32'(taddr));
    if (ep[0]) check("rom_io_out", 32'(rom_io_out), 32'(twdata));
    check("proto we_n&oe_n", 32'(!rom_we_n && !rom_oe_n), 32'(0));
    check("proto io_oe&oe_n", 32'(rom_io_oe && !rom_oe_n), 32'(0));
    if (rsp_valid) begin
      rsp_cnt++;
      last_rel   = t;
      last_rdata = rsp_rdata;
      last_err   = rsp_err;
    end
    if (!rom_we_n) begin
      if (we_first < 0) we_first = t;
      we_last = t;
    end
    if (!rom_oe_n && oe_prev) polls++;
    oe_prev = rom_oe_n;
  end

  task automatic do_req(input logic w, input logic [12:0] a, input logic [7:0] d,
                        input int busy, input logic keep);
    int start, n;
    busy_cfg  = busy;
    req_we    = w;
    req_addr  = a;
    req_wdata = d;
    req_valid = 1'b1;
    start = n_acc;
    n = 0;
    while (n_acc == start && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n_acc == start) check("accept_timeout", 32'(0), 32'(1));
    if (!keep) begin
      req_valid = 1'b0;
      req_we    = ~w;
      req_addr  = 13'h0AAA;
      req_wdata = 8'hC3;
    end
  endtask

  task automatic wait_rsp(input int target);
    int n;
    n = 0;
    while (rsp_cnt < target && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (rsp_cnt < target) check("rsp_timeout", 32'(rsp_cnt), 32'(target));
  endtask

  initial begin
    int r0, a1, a2, a3;
    repeat (3) @(negedge clk);
    check("reset req_ready", 32'(req_ready), 32'(1));
    check("reset strobes", 32'({rom_ce_n, rom_oe_n, rom_we_n, rom_io_oe}), 32'(4'b1110));
    check("reset rom_a/io_out", 32'({rom_a, rom_io_out}), 32'(0));
    check("reset rsp", 32'({rsp_valid, rsp_err, rsp_rdata}), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Plain read
    r0 = rsp_cnt;
    do_req(1'b0, 13'h0005, 8'h00, 0, 1'b0);
    wait_rsp(r0 + 1);
    check("read latency", 32'(last_rel), 32'(3));
    check("read data", 32'(last_rdata), 32'(8'hA5));
    check("read err", 32'(last_err), 32'(0));

    // Write, three busy polls then success on the fourth
    r0 = rsp_cnt;
    do_req(1'b1, 13'h1FFF, 8'h3C, 3, 1'b0);
    wait_rsp(r0 + 1);
    check("write latency", 32'(last_rel), 32'(17));
    check("write err", 32'(last_err), 32'(0));
    check("we_n first low", 32'(we_first), 32'(2));
    check("we_n last low", 32'(we_last), 32'(4));
    check("write polls", 32'(polls), 32'(4));

    r0 = rsp_cnt;
    do_req(1'b0, 13'h1FFF, 8'h00, 0, 1'b0);
    wait_rsp(r0 + 1);
    check("readback data", 32'(last_rdata), 32'(8'h3C));
    check("readback latency", 32'(last_rel), 32'(3));

    // Back-to-back with req_valid held: read, write, read
    r0 = rsp_cnt;
    do_req(1'b0, 13'h0010, 8'h00, 0, 1'b1);
    a1 = acc_cyc;
    do_req(1'b1, 13'h0020, 8'h5A, 0, 1'b1);
    a2 = acc_cyc;
    do_req(1'b0, 13'h0020, 8'h00, 0, 1'b0);
    a3 = acc_cyc;
    wait_rsp(r0 + 3);
    check("b2b accept gap rd->wr", 32'(a2 - a1), 32'(4));
    check("b2b accept gap wr->rd", 32'(a3 - a2), 32'(9));
    check("b2b response count", 32'(rsp_cnt - r0), 32'(3));
    check("b2b read data", 32'(last_rdata), 32'(8'h5A));

    // Poll timeout
    r0 = rsp_cnt;
    do_req(1'b1, 13'h0040, 8'h80, 100, 1'b0);
    wait_rsp(r0 + 1);
    check("timeout latency", 32'(last_rel), 32'(17));
    check("timeout err", 32'(last_err), 32'(1));
    check("timeout polls", 32'(polls), 32'(4));

    // Reset during the write pulse
    @(negedge clk);
    r0 = rsp_cnt;
    do_req(1'b1, 13'h0100, 8'h55, 0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    check("abort pre we_n", 32'(rom_we_n), 32'(0));
    rst_n = 1'b0;
    #1;
    check("abort we_n", 32'(rom_we_n), 32'(1));
    check("abort io_oe", 32'(rom_io_oe), 32'(0));
    check("abort ce_n/oe_n", 32'({rom_ce_n, rom_oe_n}), 32'(2'b11));
    check("abort req_ready", 32'(req_ready), 32'(1));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("abort no response", 32'(rsp_cnt), 32'(r0));
    check("abort ready after", 32'(req_ready), 32'(1));

    r0 = rsp_cnt;
    do_req(1'b0, 13'h0005, 8'h00, 0, 1'b0);
    wait_rsp(r0 + 1);
    check("post-abort read data", 32'(last_rdata), 32'(8'hA5));
    check("post-abort read latency", 32'(last_rel), 32'(3));

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/eeprom_ctrl.md
# eeprom_ctrl

Synchronous request/response controller that sits directly upstream of the at28c64 `eeprom` model. It turns single-byte read and write requests from the CPU bus into AT28C64 pin sequences on `a`, `ce`, `oe`, `we` and `io`. Writes complete by DATA-polling I/O7, with a bounded poll count. All pin outputs are registered.

## Interface
- `RD_WAIT`, default 2: cycles `ce`/`oe` are held low before `io` is sampled, ≥1.
- `WE_PULSE`, default 3: cycles `we` is held low per write, ≥1.
- `POLL_MAX`, default 4: maximum DATA polls before a write is reported as failed, ≥1.
- `clk`  in  1  Single clock. Everything is rising-edge.
- `rst_n`  in  1  Asynchronous, active-low reset.
- `req_valid`  in  1  Request present.
- `req_ready`  out  1  High only in IDLE. Accept = `req_valid && req_ready`.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  13  Byte address.
- `req_wdata`  in  8  Write data.
- `rsp_valid`  out  1  One-cycle completion pulse. There is no backpressure.
- `rsp_rdata`  out  8  Read data. Holds its value until the next read completes.
- `rsp_err`  out  1  Write poll timeout. Valid with `rsp_valid`; 0 for reads.
- `rom_a`  out  13  Drives `eeprom.a`.
- `rom_ce_n`, `rom_oe_n`, `rom_we_n`  out  1 each  Active-low strobes.
- `rom_io_out`  out  8  Write data for the top-level tristate.
- `rom_io_oe`  out  1  Controller drives `io` when high.
- `rom_io_in`  in  8  `eeprom.io` as seen by the controller.

## Operation
- On accept, latch `req_addr` into `rom_a`, and latch `req_wdata` and `req_we`. `req_*` are ignored outside the accept cycle.
- States:
  - IDLE
  - RD: `RD_WAIT` cycles
  - WR_SETUP: 1 cycle
  - WR_PULSE: `WE_PULSE` cycles
  - WR_HOLD: 1 cycle
  - POLL: `RD_WAIT` cycles
  - POLL_GAP: 1 cycle
  - RESP: 1 cycle
- IDLE:
  - Accepting a read goes to RD.
  - Accepting a write goes to WR_SETUP.
- RD: `ce_n`=0, `oe_n`=0. At the end of the last cycle, capture `rom_io_in` into `rsp_rdata` and go to RESP.
- WR_SETUP: `ce_n`=0, `we_n`=1, `io_oe`=1.
- WR_PULSE: `we_n`=0, data driven.
- WR_HOLD: `we_n`=1, data still driven.
- POLL: `ce_n`=0, `oe_n`=0, `io_oe`=0. At the end, compare `rom_io_in[7]` with the latched `wdata[7]`:
  - Equal: go to RESP with err=0.
  - Not equal, poll count < `POLL_MAX`: go to POLL_GAP.
  - Not equal on poll number `POLL_MAX`: go to RESP with err=1.
- POLL_GAP: `ce_n`=1, `oe_n`=1, increment the poll count.
- RESP: `rsp_valid`=1, strobes deasserted, next state IDLE. The poll count is cleared.
- Invariants:
  - `rom_we_n` and `rom_oe_n` are never low in the same cycle.
  - `rom_io_oe`=1 only while `rom_oe_n`=1.
  - `rom_ce_n`=1 in IDLE and RESP.
- Reset values:
  - `rom_ce_n`, `rom_oe_n`, `rom_we_n` = 1.
  - `rom_io_oe`, `rom_io_out`, `rom_a`, `rsp_rdata` = 0.
  - `rsp_valid`, `rsp_err` = 0.
  - `req_ready` = 1; state is IDLE.
- Reset mid-operation, including during WR_PULSE: all strobes go high and `io_oe` goes low asynchronously. No response is issued. The aborted write leaves the EEPROM byte undefined.

## Timing
- Accept happens in cycle 0. Timing shown for defaults (`RD_WAIT`=2, `WE_PULSE`=3).
- Read: strobes low in cycles 1..`RD_WAIT`. `rsp_valid` in cycle `RD_WAIT`+1 = 3.
- Write:
  - Setup in cycle 1.
  - `we_n` low in cycles 2..`WE_PULSE`+1 (2..4).
  - Hold in cycle 5.
  - First poll in cycles 6..7.
- First-poll success: `rsp_valid` in cycle 8.
- Each failed poll adds `RD_WAIT`+1 = 3 cycles.
- Timeout: `rsp_valid` with err=1 in cycle 8 + (`POLL_MAX`−1)·3 = 17. No gap follows the final poll.
- `req_ready` rises in the cycle after RESP. With `req_valid` held high, back-to-back requests are accepted every (latency+1) cycles.

## Test plan
- Read: memory[0x0005]=0xA5, read 0x0005 accepted in cycle 0. Require `rsp_valid` in cycle 3, `rsp_rdata`=0xA5, `rsp_err`=0.
- Write with polling: write 0x3C to 0x1FFF. The bench model returns `io[7]`=1 for 3 polls, then 0. Require `we_n` low exactly in cycles 2–4, `rsp_valid` in cycle 17, err=0. A following read of 0x1FFF returns 0x3C.
- Timeout: write 0x80 with `io[7]` stuck at 0. Require exactly 4 polls, then `rsp_valid` in cycle 17 with `rsp_err`=1.
- Back-to-back: `req_valid` held high across read, write, read. Require each accept to occur the cycle after the previous `rsp_valid`, with no lost or duplicated requests.
- Reset abort: assert `rst_n`=0 mid-WR_PULSE (cycle 3). Require `rom_we_n`=1 and `rom_io_oe`=0 before the next clock edge, no `rsp_valid`, and IDLE with `req_ready`=1 after release.
- Protocol checker on all of the above: `we_n`&`oe_n` never both 0; `io_oe` never high while `oe_n`=0.
